// File: rtl/btn_req_conditioner_if.sv
// ============================================================================
// Module : btn_req_conditioner_if
// Brief  : Button conditioner bus: raw buttons/ack in, debounced levels,
//          edge pulses and encoder request lines out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface btn_req_conditioner_if;
  logic [2:0] btn_in;
  logic       ack;
  logic [2:0] stable;
  logic [2:0] rise;
  logic       req2;
  logic       req1;
  logic       req0;
  logic       pending;

  modport master (
    output btn_in, ack,
    input  stable, rise, req2, req1, req0, pending
  );

  modport slave (
    input  btn_in, ack,
    output stable, rise, req2, req1, req0, pending
  );
endinterface

`default_nettype wire

// File: rtl/btn_req_conditioner.sv
// ============================================================================
// Module : btn_req_conditioner
// Brief  : 3-channel synchronise/debounce/rise-detect with sticky requests
//          feeding a 3-input priority encoder. BTN_REQ_LEVEL_EN selects
//          live debounced levels on req2..req0 instead of sticky requests.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_req_conditioner #(
  parameter int DEBOUNCE_CNT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  btn_req_conditioner_if.slave    bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       stable_q;
  logic [2:0]       stable_d;
  logic [2:0]       rise_q;
  logic [2:0]       rise_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       req;

  // Any cycle where the synchronised input agrees with the stable level
  // restarts the count, so only an unbroken run of DEBOUNCE_CNT flips it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == C_CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= bus.btn_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BTN_REQ_LEVEL_EN
  logic unused_ack;
  assign unused_ack = bus.ack;
  assign req        = stable_q;
`else
  logic [2:0] req_q;
  logic [2:0] req_d;

  // A new rise wins over a simultaneous ack so no press is ever lost.
  always_comb begin
    req_d = rise_q | (req_q & ~{3{bus.ack}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req_d;
  end

  assign req = req_q;
`endif

  assign bus.stable  = stable_q;
  assign bus.rise    = rise_q;
  assign bus.req2    = req[2];
  assign bus.req1    = req[1];
  assign bus.req0    = req[0];
  assign bus.pending = |req;

endmodule

`default_nettype wire

// File: tb/tb_btn_req_conditioner.sv
// ============================================================================
// Module : tb_btn_req_conditioner
// Brief  : Directed self-checking bench for btn_req_conditioner (default build).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_btn_req_conditioner;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  btn_req_conditioner_if bus ();

  btn_req_conditioner #(
    .DEBOUNCE_CNT (4),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [2:0] st,
                            input logic [2:0] ri, input logic [2:0] rq);
    chk({tag, ".stable"},  bus.stable, st);
    chk({tag, ".rise"},    bus.rise, ri);
    chk({tag, ".req"},     {bus.req2, bus.req1, bus.req0}, rq);
    chk({tag, ".pending"}, {2'b00, bus.pending}, {2'b00, |rq});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.btn_in = 3'b111;
    bus.ack    = 1'b0;

    // Reset held with all buttons pressed
    for (int k = 0; k < 3; k++) begin
      step();
      expect_all("reset", 3'b000, 3'b000, 3'b000);
    end
    rst_n      = 1'b1;
    bus.btn_in = 3'b000;
    for (int k = 0; k < 8; k++) begin
      step();
      expect_all("idle", 3'b000, 3'b000, 3'b000);
    end

    // Clean press on channel 0: stable at edge 6, request from edge 7
    bus.btn_in = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_all("press_wait", 3'b000, 3'b000, 3'b000);
    end
    step();
    expect_all("press_e6", 3'b001, 3'b001, 3'b000);
    step();
    expect_all("press_e7", 3'b001, 3'b000, 3'b001);
    for (int k = 0; k < 4; k++) begin
      step();
      expect_all("press_hold", 3'b001, 3'b000, 3'b001);
    end
    bus.ack = 1'b1;
    step();
    expect_all("press_ack", 3'b001, 3'b000, 3'b000);
    bus.ack = 1'b0;

    // Release is debounced identically and produces no rise
    bus.btn_in = 3'b000;
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_all("release_wait", 3'b001, 3'b000, 3'b000);
    end
    step();
    expect_all("release_e6", 3'b000, 3'b000, 3'b000);

    // 3-cycle glitch on channel 1 is rejected
    bus.btn_in = 3'b010;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_all("glitch_hi", 3'b000, 3'b000, 3'b000);
    end
    bus.btn_in = 3'b000;
    for (int k = 0; k < 20; k++) begin
      step();
      expect_all("glitch_lo", 3'b000, 3'b000, 3'b000);
    end

    // Bounce on channel 2: 1,1,0,0,1,1,0,0,1,1 then held high
    for (int s = 0; s < 13; s++) begin
      bus.btn_in = (s < 10 && ((s / 2) % 2) == 1) ? 3'b000 : 3'b100;
      step();
      expect_all("bounce", 3'b000, 3'b000, 3'b000);
    end
    step();
    expect_all("bounce_rise", 3'b100, 3'b100, 3'b000);
    step();
    expect_all("bounce_req", 3'b100, 3'b000, 3'b100);
    step();
    expect_all("bounce_hold", 3'b100, 3'b000, 3'b100);

    // Clear, release, then set up an ack colliding with rise[2]
    bus.ack = 1'b1;
    step();
    expect_all("clr_ack", 3'b100, 3'b000, 3'b000);
    bus.ack    = 1'b0;
    bus.btn_in = 3'b000;
    for (int k = 0; k < 6; k++) step();
    expect_all("clr_release", 3'b000, 3'b000, 3'b000);

    bus.btn_in = 3'b001;
    step();
    step();
    bus.btn_in = 3'b101;
    step();
    step();
    step();
    step();
    expect_all("coll_rise0", 3'b001, 3'b001, 3'b000);
    step();
    expect_all("coll_req0", 3'b001, 3'b000, 3'b001);
    step();
    expect_all("coll_rise2", 3'b101, 3'b100, 3'b001);
    bus.ack = 1'b1;
    step();
    expect_all("coll_ack", 3'b101, 3'b000, 3'b100);
    step();
    expect_all("ack_held", 3'b101, 3'b000, 3'b000);
    step();
    expect_all("ack_noreq", 3'b101, 3'b000, 3'b000);
    bus.ack = 1'b0;

    // Reset in the middle of a count on channel 0
    bus.btn_in = 3'b000;
    for (int k = 0; k < 6; k++) step();
    expect_all("mid_pre", 3'b000, 3'b000, 3'b000);
    bus.btn_in = 3'b001;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_all("mid_count", 3'b000, 3'b000, 3'b000);
    end
    rst_n = 1'b0;
    step();
    expect_all("mid_reset", 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_all("mid_resync", 3'b000, 3'b000, 3'b000);
    end
    step();
    expect_all("mid_rise", 3'b001, 3'b001, 3'b000);
    step();
    expect_all("mid_req", 3'b001, 3'b000, 3'b001);
    step();
    expect_all("mid_hold", 3'b001, 3'b000, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
